// File: rtl/axis_cpu_loader.sv
// axis_cpu_loader: takes configuration packets from an AXI-Stream port and writes them
// into the instruction memory, immediates table or jump-offset table, holding the CPU in reset meanwhile.
module axis_cpu_loader #(
    parameter int CODE_ADDR_WIDTH = 10
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [31:0]                cfg_TDATA,
    input  logic                       cfg_TVALID,
    output logic                       cfg_TREADY,
    input  logic                       cfg_TLAST,
    output logic [CODE_ADDR_WIDTH-1:0] inst_mem_wr_addr,
    output logic [7:0]                 inst_mem_wr_data,
    output logic                       inst_mem_wr_en,
    output logic [3:0]                 imm_wr_addr,
    output logic [31:0]                imm_wr_data,
    output logic                       imm_wr_en,
    output logic [3:0]                 jmp_off_wr_addr,
    output logic [7:0]                 jmp_off_wr_data,
    output logic                       jmp_off_wr_en,
    output logic                       cpu_hold,
    output logic                       done,
    output logic                       err
);

    typedef enum logic [2:0] {
        IDLE,
        IMEM,
        UNPACK,
        IMM,
        JMP,
        DRAIN
    } state_t;

    localparam logic [CODE_ADDR_WIDTH-1:0] CODE_ONE = CODE_ADDR_WIDTH'(1);

    state_t state, state_n;

    logic [CODE_ADDR_WIDTH-1:0] code_addr, code_addr_n;
    logic [3:0]                 tbl_addr, tbl_addr_n;
    logic [23:0]                word_buf, word_buf_n;
    logic [1:0]                 byte_cnt, byte_cnt_n;
    logic                       last_word, last_word_n;
    logic                       release_pend, release_pend_n;
    logic                       done_pend, done_pend_n;

    logic                       tready_n;
    logic [CODE_ADDR_WIDTH-1:0] inst_addr_n;
    logic [7:0]                 inst_data_n;
    logic                       inst_en_n;
    logic [3:0]                 imm_addr_n;
    logic [31:0]                imm_data_n;
    logic                       imm_en_n;
    logic [3:0]                 jmp_addr_n;
    logic [7:0]                 jmp_data_n;
    logic                       jmp_en_n;
    logic                       hold_n;
    logic                       done_n;
    logic                       err_n;

    logic       accept;
    logic [1:0] target;
    logic       unused_tdata;

    assign accept       = cfg_TVALID & cfg_TREADY;
    assign target       = cfg_TDATA[31:30];
    assign unused_tdata = ^cfg_TDATA;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    // The final strobe of a packet arms release/done pending flags so that cpu_hold drops
    // and done pulses one cycle after that strobe is visible.
    always_comb begin
        state_n        = state;
        code_addr_n    = code_addr;
        tbl_addr_n     = tbl_addr;
        word_buf_n     = word_buf;
        byte_cnt_n     = byte_cnt;
        last_word_n    = last_word;
        release_pend_n = 1'b0;
        done_pend_n    = 1'b0;
        inst_addr_n    = inst_mem_wr_addr;
        inst_data_n    = inst_mem_wr_data;
        inst_en_n      = 1'b0;
        imm_addr_n     = imm_wr_addr;
        imm_data_n     = imm_wr_data;
        imm_en_n       = 1'b0;
        jmp_addr_n     = jmp_off_wr_addr;
        jmp_data_n     = jmp_off_wr_data;
        jmp_en_n       = 1'b0;
        hold_n         = cpu_hold;
        done_n         = done_pend;
        err_n          = err;

        if (release_pend) begin
            hold_n = 1'b0;
        end

        unique case (state)
            IDLE: begin
                if (accept) begin
                    code_addr_n = cfg_TDATA[CODE_ADDR_WIDTH-1:0];
                    tbl_addr_n  = cfg_TDATA[3:0];
                    if (cfg_TLAST) begin
                        if (target == 2'd3) begin
                            err_n = 1'b1;
                        end else begin
                            done_n = 1'b1;
                        end
                    end else begin
                        hold_n = 1'b1;
                        unique case (target)
                            2'd0: state_n = IMEM;
                            2'd1: state_n = IMM;
                            2'd2: state_n = JMP;
                            default: begin
                                state_n = DRAIN;
                                err_n   = 1'b1;
                            end
                        endcase
                    end
                end
            end

            IMEM: begin
                if (accept) begin
                    inst_en_n   = 1'b1;
                    inst_addr_n = code_addr;
                    inst_data_n = cfg_TDATA[7:0];
                    code_addr_n = code_addr + CODE_ONE;
                    word_buf_n  = cfg_TDATA[31:8];
                    last_word_n = cfg_TLAST;
                    byte_cnt_n  = 2'd0;
                    state_n     = UNPACK;
                end
            end

            UNPACK: begin
                inst_en_n   = 1'b1;
                inst_addr_n = code_addr;
                inst_data_n = word_buf[7:0];
                code_addr_n = code_addr + CODE_ONE;
                word_buf_n  = {8'h00, word_buf[23:8]};
                byte_cnt_n  = byte_cnt + 2'd1;
                if (byte_cnt == 2'd2) begin
                    if (last_word) begin
                        state_n        = IDLE;
                        release_pend_n = 1'b1;
                        done_pend_n    = 1'b1;
                    end else begin
                        state_n = IMEM;
                    end
                end
            end

            IMM: begin
                if (accept) begin
                    imm_en_n   = 1'b1;
                    imm_addr_n = tbl_addr;
                    imm_data_n = cfg_TDATA;
                    tbl_addr_n = tbl_addr + 4'd1;
                    if (cfg_TLAST) begin
                        state_n        = IDLE;
                        release_pend_n = 1'b1;
                        done_pend_n    = 1'b1;
                    end
                end
            end

            JMP: begin
                if (accept) begin
                    jmp_en_n   = 1'b1;
                    jmp_addr_n = tbl_addr;
                    jmp_data_n = cfg_TDATA[7:0];
                    tbl_addr_n = tbl_addr + 4'd1;
                    if (cfg_TLAST) begin
                        state_n        = IDLE;
                        release_pend_n = 1'b1;
                        done_pend_n    = 1'b1;
                    end
                end
            end

            DRAIN: begin
                if (accept && cfg_TLAST) begin
                    state_n        = IDLE;
                    release_pend_n = 1'b1;
                end
            end

            default: begin
                state_n = IDLE;
            end
        endcase

        tready_n = (state_n != UNPACK);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            code_addr        <= '0;
            tbl_addr         <= 4'd0;
            word_buf         <= 24'd0;
            byte_cnt         <= 2'd0;
            last_word        <= 1'b0;
            release_pend     <= 1'b0;
            done_pend        <= 1'b0;
            cfg_TREADY       <= 1'b1;
            inst_mem_wr_addr <= '0;
            inst_mem_wr_data <= 8'd0;
            inst_mem_wr_en   <= 1'b0;
            imm_wr_addr      <= 4'd0;
            imm_wr_data      <= 32'd0;
            imm_wr_en        <= 1'b0;
            jmp_off_wr_addr  <= 4'd0;
            jmp_off_wr_data  <= 8'd0;
            jmp_off_wr_en    <= 1'b0;
            cpu_hold         <= 1'b0;
            done             <= 1'b0;
            err              <= 1'b0;
        end else begin
            code_addr        <= code_addr_n;
            tbl_addr         <= tbl_addr_n;
            word_buf         <= word_buf_n;
            byte_cnt         <= byte_cnt_n;
            last_word        <= last_word_n;
            release_pend     <= release_pend_n;
            done_pend        <= done_pend_n;
            cfg_TREADY       <= tready_n;
            inst_mem_wr_addr <= inst_addr_n;
            inst_mem_wr_data <= inst_data_n;
            inst_mem_wr_en   <= inst_en_n;
            imm_wr_addr      <= imm_addr_n;
            imm_wr_data      <= imm_data_n;
            imm_wr_en        <= imm_en_n;
            jmp_off_wr_addr  <= jmp_addr_n;
            jmp_off_wr_data  <= jmp_data_n;
            jmp_off_wr_en    <= jmp_en_n;
            cpu_hold         <= hold_n;
            done             <= done_n;
            err              <= err_n;
        end
    end

endmodule
